// File: rtl/cmd_frame_ctrl.sv
// UART command-frame decoder: register write/read and ALU frames, responses serialised to TX.
// Strobes are registered one cycle after the qualifying input; TX waits on tx_busy_in, and stray RX words are dropped with err_out.
module cmd_frame_ctrl #(
  parameter int               WIDTH        = 8,
  parameter int               ADDR         = 4,
  parameter int               BYTE_TIMEOUT = 1024,
  parameter int               RESP_TIMEOUT = 16,
  parameter logic [WIDTH-1:0] CMD_WR       = 'hAA,
  parameter logic [WIDTH-1:0] CMD_RD       = 'hBB,
  parameter logic [WIDTH-1:0] CMD_ALU_OP   = 'hCC,
  parameter logic [WIDTH-1:0] CMD_ALU_NOP  = 'hDD,
  parameter logic [WIDTH-1:0] ERR_CODE     = 'hEE
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   rx_data_in,
  input  logic               rx_data_valid_in,
  input  logic               tx_busy_in,
  input  logic [WIDTH-1:0]   rf_rd_data_in,
  input  logic               rf_rd_data_valid_in,
  input  logic [2*WIDTH-1:0] alu_data_in,
  input  logic               alu_data_valid_in,
  output logic               rf_wr_en_out,
  output logic               rf_rd_en_out,
  output logic [ADDR-1:0]    rf_addr_out,
  output logic [WIDTH-1:0]   rf_wr_data_out,
  output logic               alu_en_out,
  output logic [3:0]         alu_fun_out,
  output logic               clk_gate_en_out,
  output logic [WIDTH-1:0]   tx_data_out,
  output logic               tx_data_valid_out,
  output logic               err_out,
  output logic               busy_out
);

  localparam int TMAX = (BYTE_TIMEOUT > RESP_TIMEOUT) ? BYTE_TIMEOUT : RESP_TIMEOUT;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] BYTE_LAST = TW'(BYTE_TIMEOUT - 1);
  localparam logic [TW-1:0] RESP_LAST = TW'(RESP_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_GET_ADDR, S_GET_DATA, S_GET_OPA, S_GET_OPB, S_GET_FUN,
    S_WAIT_RD, S_ALU_START, S_WAIT_ALU, S_TX_LOAD, S_TX_WAIT_HI, S_TX_WAIT_LO
  } state_t;

  state_t           r_state, w_state;
  logic             r_is_rd, w_is_rd;
  logic [TW-1:0]    r_timer, w_timer;
  logic [WIDTH-1:0] r_q0, w_q0, r_q1, w_q1;
  logic [1:0]       r_qcnt, w_qcnt;
  logic [ADDR-1:0]  r_addr, w_addr;
  logic [WIDTH-1:0] r_wr_data, w_wr_data;
  logic             r_wr_en, w_wr_en, r_rd_en, w_rd_en, r_alu_en, w_alu_en;
  logic [3:0]       r_alu_fun, w_alu_fun;
  logic             r_clk_gate, w_clk_gate;
  logic [WIDTH-1:0] r_tx_data, w_tx_data;
  logic             r_tx_vld, w_tx_vld, r_err, w_err;
  logic             w_abort, w_in_get;
  logic             w_byte_to, w_resp_to;

  assign w_byte_to = (r_timer == BYTE_LAST);
  assign w_resp_to = (r_timer == RESP_LAST);
  assign w_in_get  = (r_state == S_GET_ADDR) || (r_state == S_GET_DATA) || (r_state == S_GET_OPA) ||
                     (r_state == S_GET_OPB)  || (r_state == S_GET_FUN);

  always_comb begin
    w_state    = r_state;
    w_is_rd    = r_is_rd;
    w_q0       = r_q0;
    w_q1       = r_q1;
    w_qcnt     = r_qcnt;
    w_addr     = r_addr;
    w_wr_data  = r_wr_data;
    w_wr_en    = 1'b0;
    w_rd_en    = 1'b0;
    w_alu_en   = 1'b0;
    w_alu_fun  = r_alu_fun;
    w_clk_gate = r_clk_gate;
    w_tx_data  = r_tx_data;
    w_tx_vld   = 1'b0;
    w_err      = 1'b0;
    w_abort    = 1'b0;
    case (r_state)
      S_IDLE: if (rx_data_valid_in) begin
        if (rx_data_in == CMD_WR)           begin w_is_rd = 1'b0; w_state = S_GET_ADDR; end
        else if (rx_data_in == CMD_RD)      begin w_is_rd = 1'b1; w_state = S_GET_ADDR; end
        else if (rx_data_in == CMD_ALU_OP)  w_state = S_GET_OPA;
        else if (rx_data_in == CMD_ALU_NOP) w_state = S_GET_FUN;
        else                                w_abort = 1'b1;
      end
      S_GET_ADDR: if (rx_data_valid_in) begin
        w_addr = rx_data_in[ADDR-1:0];
        if (r_is_rd) begin w_rd_en = 1'b1; w_state = S_WAIT_RD; end
        else         w_state = S_GET_DATA;
      end else if (w_byte_to) w_abort = 1'b1;
      S_GET_DATA: if (rx_data_valid_in) begin
        w_wr_data = rx_data_in; w_wr_en = 1'b1; w_state = S_IDLE;
      end else if (w_byte_to) w_abort = 1'b1;
      S_GET_OPA: if (rx_data_valid_in) begin
        w_addr = '0; w_wr_data = rx_data_in; w_wr_en = 1'b1; w_state = S_GET_OPB;
      end else if (w_byte_to) w_abort = 1'b1;
      S_GET_OPB: if (rx_data_valid_in) begin
        w_addr = ADDR'(1); w_wr_data = rx_data_in; w_wr_en = 1'b1; w_state = S_GET_FUN;
      end else if (w_byte_to) w_abort = 1'b1;
      S_GET_FUN: if (rx_data_valid_in) begin
        w_alu_fun = rx_data_in[3:0]; w_clk_gate = 1'b1; w_state = S_ALU_START;
      end else if (w_byte_to) w_abort = 1'b1;
      S_WAIT_RD: if (rf_rd_data_valid_in) begin
        w_q0 = rf_rd_data_in; w_qcnt = 2'd1; w_state = S_TX_LOAD;
      end else if (w_resp_to) w_abort = 1'b1;
      S_ALU_START: begin w_alu_en = 1'b1; w_state = S_WAIT_ALU; end
      S_WAIT_ALU: if (alu_data_valid_in) begin
        w_q0 = alu_data_in[WIDTH-1:0]; w_q1 = alu_data_in[2*WIDTH-1:WIDTH];
        w_qcnt = 2'd2; w_clk_gate = 1'b0; w_state = S_TX_LOAD;
      end else if (w_resp_to) begin
        w_clk_gate = 1'b0; w_abort = 1'b1;
      end
      S_TX_LOAD: begin
        w_tx_data = r_q0; w_tx_vld = 1'b1; w_q0 = r_q1; w_qcnt = r_qcnt - 2'd1; w_state = S_TX_WAIT_HI;
      end
      // A busy line that never rises must not wedge the controller.
      S_TX_WAIT_HI: if (tx_busy_in || w_resp_to) w_state = S_TX_WAIT_LO;
      S_TX_WAIT_LO: if (!tx_busy_in) w_state = (r_qcnt != 2'd0) ? S_TX_LOAD : S_IDLE;
      default: w_state = S_IDLE;
    endcase
    if (rx_data_valid_in && !w_in_get && (r_state != S_IDLE)) w_err = 1'b1;
    if (w_abort) begin
      w_err = 1'b1; w_q0 = ERR_CODE; w_qcnt = 2'd1; w_state = S_TX_LOAD;
    end
    w_timer = (w_state != r_state) ? '0 : r_timer + TW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;  r_is_rd <= 1'b0;  r_timer <= '0;
      r_q0 <= '0;  r_q1 <= '0;  r_qcnt <= '0;
      r_addr <= '0;  r_wr_data <= '0;  r_wr_en <= 1'b0;  r_rd_en <= 1'b0;
      r_alu_en <= 1'b0;  r_alu_fun <= '0;  r_clk_gate <= 1'b0;
      r_tx_data <= '0;  r_tx_vld <= 1'b0;  r_err <= 1'b0;
    end else begin
      r_state <= w_state;  r_is_rd <= w_is_rd;  r_timer <= w_timer;
      r_q0 <= w_q0;  r_q1 <= w_q1;  r_qcnt <= w_qcnt;
      r_addr <= w_addr;  r_wr_data <= w_wr_data;  r_wr_en <= w_wr_en;  r_rd_en <= w_rd_en;
      r_alu_en <= w_alu_en;  r_alu_fun <= w_alu_fun;  r_clk_gate <= w_clk_gate;
      r_tx_data <= w_tx_data;  r_tx_vld <= w_tx_vld;  r_err <= w_err;
    end
  end

  assign rf_wr_en_out      = r_wr_en;
  assign rf_rd_en_out      = r_rd_en;
  assign rf_addr_out       = r_addr;
  assign rf_wr_data_out    = r_wr_data;
  assign alu_en_out        = r_alu_en;
  assign alu_fun_out       = r_alu_fun;
  assign clk_gate_en_out   = r_clk_gate;
  assign tx_data_out       = r_tx_data;
  assign tx_data_valid_out = r_tx_vld;
  assign err_out           = r_err;
  assign busy_out          = (r_state != S_IDLE);

endmodule

// File: tb/tb_cmd_frame_ctrl.sv
// Scoreboard bench for cmd_frame_ctrl with simple TX-busy, register-file and ALU responders.
module tb_cmd_frame_ctrl;
  localparam int W  = 8;
  localparam int A  = 4;
  localparam int BT = 1024;
  localparam int RT = 16;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [W-1:0]   rx_data_in = '0;
  logic           rx_data_valid_in = 1'b0;
  logic           tx_busy_in = 1'b0;
  logic [W-1:0]   rf_rd_data_in = '0;
  logic           rf_rd_data_valid_in = 1'b0;
  logic [2*W-1:0] alu_data_in = '0;
  logic           alu_data_valid_in = 1'b0;
  logic           rf_wr_en_out, rf_rd_en_out, alu_en_out, clk_gate_en_out;
  logic [A-1:0]   rf_addr_out;
  logic [W-1:0]   rf_wr_data_out, tx_data_out;
  logic [3:0]     alu_fun_out;
  logic           tx_data_valid_out, err_out, busy_out;

  cmd_frame_ctrl #(.WIDTH(W), .ADDR(A), .BYTE_TIMEOUT(BT), .RESP_TIMEOUT(RT)) dut (
    .clk(clk), .reset_n(reset_n),
    .rx_data_in(rx_data_in), .rx_data_valid_in(rx_data_valid_in), .tx_busy_in(tx_busy_in),
    .rf_rd_data_in(rf_rd_data_in), .rf_rd_data_valid_in(rf_rd_data_valid_in),
    .alu_data_in(alu_data_in), .alu_data_valid_in(alu_data_valid_in),
    .rf_wr_en_out(rf_wr_en_out), .rf_rd_en_out(rf_rd_en_out), .rf_addr_out(rf_addr_out),
    .rf_wr_data_out(rf_wr_data_out), .alu_en_out(alu_en_out), .alu_fun_out(alu_fun_out),
    .clk_gate_en_out(clk_gate_en_out), .tx_data_out(tx_data_out),
    .tx_data_valid_out(tx_data_valid_out), .err_out(err_out), .busy_out(busy_out)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  logic [W-1:0]   exp_tx[$];
  logic [A+W-1:0] exp_wr[$];
  logic [W-1:0]   mon_tx_e;
  logic [A+W-1:0] mon_wr_e;
  int tx_cnt = 0, wr_cnt = 0, rd_cnt = 0, err_cnt = 0, alu_en_cnt = 0, tx_in_busy = 0;
  int cg_rise_cyc = -1, alu_en_cyc = -1;
  logic [A-1:0]   rd_addr_seen = '0;
  logic [3:0]     alu_fun_seen = '0;
  logic           prev_cg = 1'b0;
  logic [W-1:0]   rd_resp = '0;
  logic [2*W-1:0] alu_resp = '0;
  bit             alu_resp_en = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: compares strobed outputs against the scoreboard queues.
  always @(negedge clk) begin
    if (tx_data_valid_out) begin
      tx_cnt++;
      if (tx_busy_in) tx_in_busy++;
      checks++;
      if (exp_tx.size() == 0) begin
        failures++; $display("FAIL tx_unexpected got=%h required=none", tx_data_out);
      end else begin
        mon_tx_e = exp_tx.pop_front();
        if (tx_data_out !== mon_tx_e) begin
          failures++; $display("FAIL tx_word got=%h required=%h", tx_data_out, mon_tx_e);
        end
      end
    end
    if (rf_wr_en_out) begin
      wr_cnt++;
      checks++;
      if (exp_wr.size() == 0) begin
        failures++; $display("FAIL wr_unexpected got=%h/%h required=none", rf_addr_out, rf_wr_data_out);
      end else begin
        mon_wr_e = exp_wr.pop_front();
        if ({rf_addr_out, rf_wr_data_out} !== mon_wr_e) begin
          failures++; $display("FAIL wr_event got=%h required=%h", {rf_addr_out, rf_wr_data_out}, mon_wr_e);
        end
      end
    end
    if (rf_rd_en_out) begin rd_cnt++; rd_addr_seen = rf_addr_out; end
    if (err_out) err_cnt++;
    if (alu_en_out) begin alu_en_cnt++; alu_en_cyc = cyc; alu_fun_seen = alu_fun_out; end
    if (clk_gate_en_out && !prev_cg) cg_rise_cyc = cyc;
    prev_cg = clk_gate_en_out;
  end

  initial forever begin
    @(negedge clk); #1;
    if (tx_data_valid_out) begin
      tx_busy_in = 1'b1;
      repeat (10) @(negedge clk);
      tx_busy_in = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk); #1;
    if (rf_rd_en_out) begin
      repeat (3) @(negedge clk);
      rf_rd_data_in = rd_resp; rf_rd_data_valid_in = 1'b1;
      @(negedge clk);
      rf_rd_data_valid_in = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk); #1;
    if (alu_en_out && alu_resp_en) begin
      repeat (4) @(negedge clk);
      alu_data_in = alu_resp; alu_data_valid_in = 1'b1;
      @(negedge clk);
      alu_data_valid_in = 1'b0;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic send_word(input logic [W-1:0] w, input int gap);
    @(negedge clk);
    rx_data_in = w; rx_data_valid_in = 1'b1;
    @(negedge clk);
    rx_data_valid_in = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy_out) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rf_wr_en_out, rf_rd_en_out, rf_addr_out, rf_wr_data_out, alu_en_out, alu_fun_out,
         clk_gate_en_out, tx_data_out, tx_data_valid_out, err_out, busy_out} !== '0) begin
      failures++; $display("FAIL reset_outputs some output nonzero, required all 0");
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    int e0, t0, w0;
    e0 = err_cnt; t0 = tx_cnt; w0 = wr_cnt;
    exp_wr.push_back({4'h5, 8'h3C});
    send_word(8'hAA, 20); send_word(8'h05, 20); send_word(8'h3C, 20);
    checks++; if (exp_wr.size() != 0) begin failures++; $display("FAIL write_done pending=%0d required=0", exp_wr.size()); end
    checks++; if (wr_cnt - w0 != 1) begin failures++; $display("FAIL write_pulses got=%0d required=1", wr_cnt - w0); end
    checks++; if (tx_cnt != t0) begin failures++; $display("FAIL write_no_tx got=%0d required=0", tx_cnt - t0); end
    checks++; if (busy_out !== 1'b0) begin failures++; $display("FAIL write_busy got=%b required=0", busy_out); end
    checks++; if (err_cnt != e0) begin failures++; $display("FAIL write_err got=%0d required=0", err_cnt - e0); end
  endtask

  task automatic test_read();
    bit ok; int r0;
    r0 = rd_cnt; rd_resp = 8'h3C;
    exp_tx.push_back(8'h3C);
    send_word(8'hBB, 0); send_word(8'h05, 0);
    wait_idle(ok);
    checks++; if (!ok) begin failures++; $display("FAIL read_idle got=busy required=idle"); end
    checks++; if (rd_cnt - r0 != 1) begin failures++; $display("FAIL read_pulses got=%0d required=1", rd_cnt - r0); end
    checks++; if (rd_addr_seen !== 4'h5) begin failures++; $display("FAIL read_addr got=%h required=5", rd_addr_seen); end
    checks++; if (exp_tx.size() != 0) begin failures++; $display("FAIL read_tx pending=%0d required=0", exp_tx.size()); end
  endtask

  task automatic test_alu_op();
    bit ok;
    alu_resp = 16'h0015; alu_resp_en = 1'b1; cg_rise_cyc = -1; alu_en_cyc = -1;
    exp_wr.push_back({4'h0, 8'h07}); exp_wr.push_back({4'h1, 8'h03});
    exp_tx.push_back(8'h15); exp_tx.push_back(8'h00);
    send_word(8'hCC, 0); send_word(8'h07, 0); send_word(8'h03, 0); send_word(8'h00, 0);
    wait_idle(ok);
    checks++; if (!ok) begin failures++; $display("FAIL alu_idle got=busy required=idle"); end
    checks++; if (exp_wr.size() != 0) begin failures++; $display("FAIL alu_opwrites pending=%0d required=0", exp_wr.size()); end
    checks++; if (exp_tx.size() != 0) begin failures++; $display("FAIL alu_tx pending=%0d required=0", exp_tx.size()); end
    checks++; if (cg_rise_cyc < 0 || alu_en_cyc - cg_rise_cyc != 1) begin
      failures++; $display("FAIL alu_gate_order gate=%0d en=%0d required en=gate+1", cg_rise_cyc, alu_en_cyc);
    end
    checks++; if (alu_fun_seen !== 4'h0) begin failures++; $display("FAIL alu_fun got=%h required=0", alu_fun_seen); end
    checks++; if (clk_gate_en_out !== 1'b0) begin failures++; $display("FAIL alu_gate_low got=%b required=0", clk_gate_en_out); end
    checks++; if (tx_in_busy != 0) begin failures++; $display("FAIL alu_tx_while_busy got=%0d required=0", tx_in_busy); end
  endtask

  task automatic test_errors();
    bit ok; int e0, w0;
    e0 = err_cnt;
    exp_tx.push_back(8'hEE);
    send_word(8'h5A, 0);
    wait_idle(ok);
    checks++; if (!ok || err_cnt - e0 != 1) begin failures++; $display("FAIL unknown_err got=%0d required=1", err_cnt - e0); end
    checks++; if (exp_tx.size() != 0) begin failures++; $display("FAIL unknown_tx pending=%0d required=0", exp_tx.size()); end
    e0 = err_cnt; w0 = wr_cnt;
    exp_tx.push_back(8'hEE);
    send_word(8'hAA, 0); send_word(8'h05, 0);
    repeat (BT - 10) @(negedge clk);
    checks++; if (err_cnt != e0 || busy_out !== 1'b1) begin
      failures++; $display("FAIL stall_early err=%0d busy=%b required err=0 busy=1", err_cnt - e0, busy_out);
    end
    repeat (20) @(negedge clk);
    checks++; if (err_cnt - e0 != 1) begin failures++; $display("FAIL stall_err got=%0d required=1", err_cnt - e0); end
    wait_idle(ok);
    checks++; if (!ok || exp_tx.size() != 0) begin failures++; $display("FAIL stall_tx pending=%0d required=0", exp_tx.size()); end
    checks++; if (wr_cnt != w0) begin failures++; $display("FAIL stall_no_write got=%0d required=0", wr_cnt - w0); end
  endtask

  task automatic test_nop_timeout();
    bit ok; int e0, a0;
    e0 = err_cnt; a0 = alu_en_cnt; alu_resp_en = 1'b0;
    exp_tx.push_back(8'hEE);
    send_word(8'hDD, 0); send_word(8'h02, 0);
    wait_idle(ok);
    checks++; if (!ok || err_cnt - e0 != 1) begin failures++; $display("FAIL nop_err got=%0d required=1", err_cnt - e0); end
    checks++; if (exp_tx.size() != 0) begin failures++; $display("FAIL nop_tx pending=%0d required=0", exp_tx.size()); end
    checks++; if (clk_gate_en_out !== 1'b0) begin failures++; $display("FAIL nop_gate got=%b required=0", clk_gate_en_out); end
    checks++; if (alu_fun_seen !== 4'h2 || alu_en_cnt - a0 != 1) begin
      failures++; $display("FAIL nop_fun got=%h/%0d required=2/1", alu_fun_seen, alu_en_cnt - a0);
    end
    alu_resp_en = 1'b1;
  endtask

  task automatic test_reset_mid_tx();
    bit seen; int t0;
    t0 = tx_cnt; alu_resp = 16'hA55A; seen = 1'b0;
    exp_wr.push_back({4'h0, 8'h11}); exp_wr.push_back({4'h1, 8'h22});
    exp_tx.push_back(8'h5A); exp_tx.push_back(8'hA5);
    send_word(8'hCC, 0); send_word(8'h11, 0); send_word(8'h22, 0); send_word(8'h03, 0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_cnt > t0) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin failures++; $display("FAIL rst_first_word got=none required=5A"); end
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({rf_wr_en_out, rf_rd_en_out, rf_addr_out, rf_wr_data_out, alu_en_out, alu_fun_out,
         clk_gate_en_out, tx_data_out, tx_data_valid_out, err_out, busy_out} !== '0) begin
      failures++; $display("FAIL rst_mid_outputs tx=%h addr=%h busy=%b required all 0", tx_data_out, rf_addr_out, busy_out);
    end
    checks++; if (exp_tx.size() != 1) begin failures++; $display("FAIL rst_mid_pending got=%0d required=1", exp_tx.size()); end
    exp_tx.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (tx_cnt != t0 + 1) begin failures++; $display("FAIL rst_no_second got=%0d required=1", tx_cnt - t0); end
    checks++; if (busy_out !== 1'b0 || exp_wr.size() != 0) begin
      failures++; $display("FAIL rst_after busy=%b wr_pending=%0d required 0/0", busy_out, exp_wr.size());
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_alu_op();
    test_errors();
    test_nop_timeout();
    test_reset_mid_tx();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmd_frame_ctrl.md
Name: cmd_frame_ctrl

Overview:
- Parametrised, single-clock command-frame controller in the ref_clk domain.
- Consumes synchronised UART RX words, decodes register-write, register-read and ALU command frames, and drives reg-file/ALU/clock-gate control.
- Serialises multi-word responses to UART TX with a busy-based handshake.
- Adds what the current controller lacks: parametrised word/address width and command codes, inter-byte and response timeouts, and error reporting.

Parameters:
- WIDTH, 8, data/command word width.
- ADDR, 4, register-file address width.
- BYTE_TIMEOUT, 1024, max idle cycles between words of one frame.
- RESP_TIMEOUT, 16, max cycles waiting for rf/alu valid, or for TX busy to rise.
- CMD_WR, 'hAA, write frame: CMD, ADDR, DATA.
- CMD_RD, 'hBB, read frame: CMD, ADDR.
- CMD_ALU_OP, 'hCC, ALU frame with operands: CMD, A, B, FUN.
- CMD_ALU_NOP, 'hDD, ALU frame without operands: CMD, FUN.
- ERR_CODE, 'hEE, word transmitted on any frame error.

Ports:
- clk  in  1  ref clock
- reset_n  in  1  asynchronous active-low reset
- rx_data_in  in  WIDTH  synchronised RX word
- rx_data_valid_in  in  1  one-cycle pulse qualifying rx_data_in
- tx_busy_in  in  1  synchronised UART TX busy
- rf_rd_data_in  in  WIDTH  register read data
- rf_rd_data_valid_in  in  1  read data valid
- alu_data_in  in  2*WIDTH  ALU result
- alu_data_valid_in  in  1  ALU result valid
- rf_wr_en_out  out  1  register write strobe
- rf_rd_en_out  out  1  register read strobe
- rf_addr_out  out  ADDR  register address
- rf_wr_data_out  out  WIDTH  register write data
- alu_en_out  out  1  ALU start pulse
- alu_fun_out  out  4  ALU function
- clk_gate_en_out  out  1  ALU clock-gate enable
- tx_data_out  out  WIDTH  TX word
- tx_data_valid_out  out  1  TX word strobe
- err_out  out  1  one-cycle error pulse
- busy_out  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: one clock, asynchronous active-low reset on reset_n. While reset_n is low, all outputs are 0 and the FSM is in IDLE. Reset mid-frame or mid-TX abandons the operation with no further strobes.

States:
- IDLE
- GET_ADDR, GET_DATA
- GET_OPA, GET_OPB, GET_FUN
- WAIT_RD
- ALU_START, WAIT_ALU
- TX_LOAD, TX_WAIT_HI, TX_WAIT_LO

Frame decode:
- IDLE + valid word equal to a command code selects the branch: WR/RD go to GET_ADDR; ALU_OP goes to GET_OPA; ALU_NOP goes to GET_FUN.
- An unknown code pulses err_out and queues ERR_CODE (goes to TX_LOAD).

Register write/read:
- WR: ADDR is latched into rf_addr_out. On the DATA word, rf_wr_en_out pulses for 1 cycle with rf_wr_data_out = DATA, registered (cycle after valid). No response word; return to IDLE.
- RD: the cycle after ADDR, rf_rd_en_out pulses for 1 cycle. In WAIT_RD, rf_rd_data_valid_in captures 1 response word.

ALU:
- ALU_OP: A is written to address 0 and B to address 1, each via a 1-cycle rf_wr_en_out pulse the cycle after receipt.
- On FUN, alu_fun_out = FUN[3:0] is latched and clk_gate_en_out rises. alu_en_out pulses 1 cycle in ALU_START, one cycle after clk_gate_en_out rises.
- In WAIT_ALU, alu_data_valid_in captures 2 words, low half first. clk_gate_en_out drops the cycle after capture or timeout.

Timeouts:
- Counters reset on every accepted word or state change.
- In a GET_* state, BYTE_TIMEOUT cycles with no valid word aborts the frame: err_out pulse, ERR_CODE queued.
- In WAIT_RD/WAIT_ALU, RESP_TIMEOUT cycles without valid: err_out pulse, ERR_CODE queued in place of the data.

TX handshake:
- TX_LOAD: tx_data_out is set, tx_data_valid_out is pulsed 1 cycle, then TX_WAIT_HI.
- TX_WAIT_HI waits for tx_busy_in = 1. If it does not rise within RESP_TIMEOUT cycles, proceed as if the word was sent.
- TX_WAIT_LO waits for tx_busy_in = 0, then loads the next queued word or returns to IDLE.
- tx_data_out holds its value between strobes.

Other rules:
- A word arriving in any non-GET state is dropped with an err_out pulse. A command is never started mid-response.
- Queue depth is 2 words; the FSM never queues more.
- A command word received in a GET state is treated as data, not a new command.

Test Plan:
- AA,05,3C spaced 20 cycles -> single rf_wr_en_out pulse, addr 5, data 3C; no TX; busy_out low afterwards.
- BB,05, then rf_rd_data_valid_in with 3C after 3 cycles; busy modelled high for 10 cycles per word -> rd_en pulse at addr 5; tx 3C once.
- CC,07,03,00, ALU returns 0x0015 -> writes 07@0 and 03@1; clk_gate_en before alu_en; fun 0; tx 15 then 00, second strobe only after busy falls.
- 5A, then separately AA,05 followed by BYTE_TIMEOUT+1 idle cycles -> unknown code: err_out pulse and tx EE; stalled frame: err_out pulse and tx EE; FSM back in IDLE.
- DD,02 with alu valid never asserted -> tx EE after RESP_TIMEOUT; clk_gate_en_out low.
- reset_n asserted during TX_WAIT_LO of an ALU response -> all outputs 0 immediately; no second word after release.
